// File: rtl/baccarat_dealer.sv
// Baccarat deal-and-score engine. A free-running 1..13 counter supplies the
// card ranks, six card registers hold both hands, and a small FSM applies the
// third-card rules before reporting the scores and the winner.
module baccarat_dealer (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       done,
  output logic       player_win,
  output logic       dealer_win
);

  typedef enum logic [3:0] {
    S_P1, S_D1, S_P2, S_D2, S_CHK, S_P3, S_CHK3, S_D3, S_DONE
  } state_t;

  // Card slot indices, in dealing order.
  localparam int C_P1 = 0;
  localparam int C_D1 = 1;
  localparam int C_P2 = 2;
  localparam int C_D2 = 3;
  localparam int C_P3 = 4;
  localparam int C_D3 = 5;

  state_t            state, state_nx;
  logic [3:0]        ctr;
  logic [5:0][3:0]   cards;
  logic [5:0]        ld;
  logic              clr;
  logic [3:0]        p3_val;

  // Rank to baccarat value: A..9 count face value, 10..K and empty count 0.
  function automatic logic [3:0] card_val(input logic [3:0] r);
    return (r >= 4'd1 && r <= 4'd9) ? r : 4'd0;
  endfunction

  // Hand score: sum at 6 bits, then mod 10.
  function automatic logic [3:0] hand_score(input logic [3:0] a, b, c);
    logic [5:0] s;
    logic [5:0] m;
    s = {2'b00, card_val(a)} + {2'b00, card_val(b)} + {2'b00, card_val(c)};
    m = s % 6'd10;
    return m[3:0];
  endfunction

  assign pcard1 = cards[C_P1];
  assign dcard1 = cards[C_D1];
  assign pcard2 = cards[C_P2];
  assign dcard2 = cards[C_D2];
  assign pcard3 = cards[C_P3];
  assign dcard3 = cards[C_D3];

  assign pscore = hand_score(pcard1, pcard2, pcard3);
  assign dscore = hand_score(dcard1, dcard2, dcard3);
  assign p3_val = card_val(pcard3);

  assign done       = (state == S_DONE);
  // A tie raises both flags.
  assign player_win = done && (pscore >= dscore);
  assign dealer_win = done && (dscore >= pscore);

  // Free-running rank counter, 1..13 with wrap back to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ctr <= 4'd1;
    else if (ctr == 4'd13) ctr <= 4'd1;
    else                  ctr <= ctr + 4'd1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_P1;
    else     state <= state_nx;
  end

  // Next state and card-load strobes; check states ignore deal.
  always_comb begin
    state_nx = state;
    ld       = '0;
    clr      = 1'b0;
    case (state)
      S_P1: if (deal) begin ld[C_P1] = 1'b1; state_nx = S_D1; end
      S_D1: if (deal) begin ld[C_D1] = 1'b1; state_nx = S_P2; end
      S_P2: if (deal) begin ld[C_P2] = 1'b1; state_nx = S_D2; end
      S_D2: if (deal) begin ld[C_D2] = 1'b1; state_nx = S_CHK; end
      S_CHK: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) state_nx = S_DONE;
        else if (pscore <= 4'd5)              state_nx = S_P3;
        else if (dscore <= 4'd5)              state_nx = S_D3;
        else                                  state_nx = S_DONE;
      end
      S_P3: if (deal) begin ld[C_P3] = 1'b1; state_nx = S_CHK3; end
      S_CHK3: begin
        state_nx = S_DONE;
        case (dscore)
          4'd0, 4'd1, 4'd2: state_nx = S_D3;
          4'd3: if (p3_val != 4'd8)                     state_nx = S_D3;
          4'd4: if (p3_val >= 4'd2 && p3_val <= 4'd7)   state_nx = S_D3;
          4'd5: if (p3_val >= 4'd4 && p3_val <= 4'd7)   state_nx = S_D3;
          4'd6: if (p3_val >= 4'd6 && p3_val <= 4'd7)   state_nx = S_D3;
          default: state_nx = S_DONE;
        endcase
      end
      S_D3: if (deal) begin ld[C_D3] = 1'b1; state_nx = S_DONE; end
      S_DONE: if (deal) begin clr = 1'b1; state_nx = S_P1; end
      default: state_nx = S_P1;
    endcase
  end

  // Card registers: clear on a new round, otherwise capture ctr on a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cards <= '0;
    end else if (clr) begin
      cards <= '0;
    end else begin
      for (int i = 0; i < 6; i++)
        if (ld[i]) cards[i] <= ctr;
    end
  end

endmodule

// File: tb/tb_baccarat_dealer.sv
// Bench for baccarat_dealer: directed rounds from the table rules plus random
// deal traffic, all checked against a slot/queue style model of the round.
module tb_baccarat_dealer;

  logic       clk = 1'b0;
  logic       rst, deal;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
  logic       done, player_win, dealer_win;

  baccarat_dealer dut (
    .clk(clk), .rst(rst), .deal(deal),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore),
    .done(done), .player_win(player_win), .dealer_win(dealer_win)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: next rank, both hands, the next slot a deal fills (6 = round over,
  // next deal clears) and whether the coming edge is a rule-check edge.
  int ctr_m;
  int pc[3];
  int dc[3];
  int slot;
  int busy;

  function automatic int val(input int r);
    return (r >= 1 && r <= 9) ? r : 0;
  endfunction

  function automatic int pscore_m();
    return (val(pc[0]) + val(pc[1]) + val(pc[2])) % 10;
  endfunction

  function automatic int dscore_m();
    return (val(dc[0]) + val(dc[1]) + val(dc[2])) % 10;
  endfunction

  function automatic bit banker_draws(input int ds, input int v);
    case (ds)
      0, 1, 2: return 1'b1;
      3:       return v != 8;
      4:       return v >= 2 && v <= 7;
      5:       return v >= 4 && v <= 7;
      6:       return v >= 6 && v <= 7;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    ctr_m = 1; slot = 0; busy = 0;
    for (int i = 0; i < 3; i++) begin pc[i] = 0; dc[i] = 0; end
  endtask

  // One rising edge of the round as the table rules describe it.
  task automatic model_edge(input bit d);
    int ps, ds;
    if (busy > 0) begin
      busy = 0;
    end else if (d) begin
      if (slot == 6) begin
        for (int i = 0; i < 3; i++) begin pc[i] = 0; dc[i] = 0; end
        slot = 0;
      end else begin
        if (slot % 2 == 0) pc[slot / 2] = ctr_m;
        else               dc[slot / 2] = ctr_m;
        ps = pscore_m();
        ds = dscore_m();
        case (slot)
          3: begin
            busy = 1;
            if (ps >= 8 || ds >= 8) slot = 6;
            else if (ps <= 5)       slot = 4;
            else if (ds <= 5)       slot = 5;
            else                    slot = 6;
          end
          4: begin
            busy = 1;
            slot = banker_draws(ds, val(pc[2])) ? 5 : 6;
          end
          5: slot = 6;
          default: slot = slot + 1;
        endcase
      end
    end
    ctr_m = (ctr_m == 13) ? 1 : ctr_m + 1;
  endtask

  task automatic expect_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit dn;
    dn = (slot == 6) && (busy == 0);
    expect_eq({tag, ".pcard1"}, {4'd0, pcard1}, 8'(pc[0]));
    expect_eq({tag, ".pcard2"}, {4'd0, pcard2}, 8'(pc[1]));
    expect_eq({tag, ".pcard3"}, {4'd0, pcard3}, 8'(pc[2]));
    expect_eq({tag, ".dcard1"}, {4'd0, dcard1}, 8'(dc[0]));
    expect_eq({tag, ".dcard2"}, {4'd0, dcard2}, 8'(dc[1]));
    expect_eq({tag, ".dcard3"}, {4'd0, dcard3}, 8'(dc[2]));
    expect_eq({tag, ".pscore"}, {4'd0, pscore}, 8'(pscore_m()));
    expect_eq({tag, ".dscore"}, {4'd0, dscore}, 8'(dscore_m()));
    expect_eq({tag, ".done"}, {7'd0, done}, {7'd0, dn});
    expect_eq({tag, ".player_win"}, {7'd0, player_win},
              {7'd0, dn && pscore_m() >= dscore_m()});
    expect_eq({tag, ".dealer_win"}, {7'd0, dealer_win},
              {7'd0, dn && dscore_m() >= pscore_m()});
  endtask

  task automatic step(input bit d);
    deal = d;
    @(posedge clk);
    model_edge(d);
    #1;
    deal = 1'b0;
    check_all("step");
  endtask

  // Idle until the counter shows rank r outside a check edge, then deal.
  task automatic deal_rank(input int r);
    for (int i = 0; i < 30 && (ctr_m != r || busy > 0); i++) step(1'b0);
    step(1'b1);
  endtask

  // Finish the current round and deal the clearing card.
  task automatic new_round();
    for (int i = 0; i < 10 && !(slot == 6 && busy == 0); i++) step(1'b1);
    step(1'b1);
    expect_eq("clear.done", {7'd0, done}, 8'd0);
    expect_eq("clear.pcard1", {4'd0, pcard1}, 8'd0);
    expect_eq("clear.dcard3", {4'd0, dcard3}, 8'd0);
  endtask

  initial begin
    rst  = 1'b1;
    deal = 1'b0;
    model_reset();
    #2 check_all("reset");
    #10 rst = 1'b0;

    // First deal after reset loads rank 1; async reset mid-round.
    step(1'b1);
    expect_eq("first.pcard1", {4'd0, pcard1}, 8'd1);
    step(1'b1);
    expect_eq("first.dcard1", {4'd0, dcard1}, 8'd2);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    expect_eq("async_rst.pcard1", {4'd0, pcard1}, 8'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    step(1'b1);
    expect_eq("rst_rel.pcard1", {4'd0, pcard1}, 8'd1);
    new_round();

    // Natural 9 vs 5, with a deal during CHK that must be dropped.
    deal_rank(4); deal_rank(2); deal_rank(5); deal_rank(3);
    step(1'b1);
    expect_eq("nat.pscore", {4'd0, pscore}, 8'd9);
    expect_eq("nat.dscore", {4'd0, dscore}, 8'd5);
    expect_eq("nat.pcard3", {4'd0, pcard3}, 8'd0);
    expect_eq("nat.done", {7'd0, done}, 8'd1);
    expect_eq("nat.player_win", {7'd0, player_win}, 8'd1);
    expect_eq("nat.dealer_win", {7'd0, dealer_win}, 8'd0);
    new_round();

    // Player draws 6, banker on 7 stands.
    deal_rank(10); deal_rank(7); deal_rank(13); deal_rank(10);
    deal_rank(6);
    step(1'b0);
    expect_eq("pdraw.pscore", {4'd0, pscore}, 8'd6);
    expect_eq("pdraw.dcard3", {4'd0, dcard3}, 8'd0);
    expect_eq("pdraw.dealer_win", {7'd0, dealer_win}, 8'd1);
    new_round();

    // Banker on 6 draws against a third card of 7.
    deal_rank(2); deal_rank(1); deal_rank(3); deal_rank(5);
    deal_rank(7); deal_rank(13);
    step(1'b0);
    expect_eq("bdraw.pscore", {4'd0, pscore}, 8'd2);
    expect_eq("bdraw.dscore", {4'd0, dscore}, 8'd6);
    expect_eq("bdraw.dcard3", {4'd0, dcard3}, 8'd13);
    expect_eq("bdraw.dealer_win", {7'd0, dealer_win}, 8'd1);
    new_round();

    // Same hands, third card 8: banker stands.
    deal_rank(2); deal_rank(1); deal_rank(3); deal_rank(5);
    deal_rank(8);
    step(1'b0);
    expect_eq("bstand.done", {7'd0, done}, 8'd1);
    expect_eq("bstand.dcard3", {4'd0, dcard3}, 8'd0);
    expect_eq("bstand.pscore", {4'd0, pscore}, 8'd3);
    new_round();

    // Banker-only draw ending in a tie.
    deal_rank(3); deal_rank(2); deal_rank(3); deal_rank(2);
    deal_rank(2);
    step(1'b0);
    expect_eq("tie.dscore", {4'd0, dscore}, 8'd6);
    expect_eq("tie.player_win", {7'd0, player_win}, 8'd1);
    expect_eq("tie.dealer_win", {7'd0, dealer_win}, 8'd1);
    new_round();

    // Counter wrap: deal on 13, then the very next edge gives 1.
    deal_rank(13);
    step(1'b1);
    expect_eq("wrap.pcard1", {4'd0, pcard1}, 8'd13);
    expect_eq("wrap.dcard1", {4'd0, dcard1}, 8'd1);
    new_round();

    // Random deal traffic against the model.
    for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/baccarat_dealer.md
# baccarat_dealer

Deal-and-score engine for the baccarat table. It draws pseudo-random card ranks from a free-running counter and holds the player and banker hands in six 4-bit card registers, which drive the per-card seven-segment decoders directly. It also applies the baccarat third-card rules and reports the hand scores and the winner. It sits between the debounced deal key and the HEX display decoders.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- deal  in  1  one-cycle deal request (already synchronised and edge-detected upstream)
- pcard1, pcard2, pcard3  out  4  player cards; 0 = empty, 1..13 = A..K
- dcard1, dcard2, dcard3  out  4  banker cards; same encoding
- pscore  out  4  player hand score, 0..9
- dscore  out  4  banker hand score, 0..9
- done  out  1  round complete
- player_win  out  1  player score above banker score, valid while done
- dealer_win  out  1  banker score above player score, valid while done; a tie asserts both flags

## Operation
- Card source: 4-bit counter ctr.
  - Reset value 1.
  - Increments every clk: 1..13, then 13 wraps to 1.
  - Never holds 0 or 14..15.
- Card value: ranks 1..9 map to their own value; ranks 10..13 and empty map to 0.
- Score: (sum of the three card values of that hand) mod 10.
  - Combinational from the card registers.
  - Computed at 6 bits, then reduced mod 10.
- FSM states and transitions:
  - P1 --deal--> D1 --deal--> P2 --deal--> D2 --deal--> CHK (automatic). Each deal loads ctr into pcard1, dcard1, pcard2, dcard2 in that order.
  - CHK, one cycle, no deal needed:
    - pscore or dscore is 8 or 9 (natural): go to DONE.
    - Else pscore 0..5: go to P3.
    - Else dscore 0..5: go to D3.
    - Else: go to DONE.
  - P3 --deal--> CHK3. The deal loads pcard3.
  - CHK3, one cycle. Let v = value of pcard3. The banker draws (go to D3) when:
    - dscore 0..2: always;
    - dscore 3: v != 8;
    - dscore 4: v in 2..7;
    - dscore 5: v in 4..7;
    - dscore 6: v in 6..7;
    - dscore 7: never.
    - Otherwise go to DONE.
  - D3 --deal--> DONE. The deal loads dcard3.
  - DONE --deal--> P1. This deal clears all six cards to 0 and loads no card.
- Ignored deals:
  - deal while in CHK or CHK3 is dropped, with no side effect.
  - deal without a pending draw has no effect.
- done = (state == DONE). player_win and dealer_win are 0 outside DONE.
- rst mid-round (asynchronous):
  - all cards go to 0 immediately;
  - ctr goes to 1;
  - state goes to P1;
  - all flags go to 0.

## Timing
- Reset values:
  - all card outputs, pscore and dscore: 0;
  - done, player_win, dealer_win: 0;
  - ctr: 1; state: P1.
- A card loads the ctr value present at the rising edge where deal=1. It is visible on the card output and in the scores after that edge, with 1-cycle latency.
- ctr advances on the same edge. Deals on consecutive cycles load consecutive ranks.
- CHK and CHK3 each last exactly one cycle. Worst-case deal-to-DONE from D2 with no draws: 2 edges.
- done and the win flags are combinational from the state and scores. They are valid in the cycle after entry to DONE.
- deal held high for several cycles counts as one request per cycle. Upstream guarantees single-cycle pulses.

## Test plan
- Reset: assert rst mid-round with cards loaded -> all cards 0, scores 0, done 0, wins 0 immediately. After release, the first deal on the edge where ctr=1 loads pcard1=1.
- Natural: deal P=4, D=2, P=5, D=3 -> pscore 9, dscore 5. CHK goes to DONE, pcard3 = dcard3 = 0, player_win=1, dealer_win=0.
- Player draws, banker stands: P=10,13 (0), D=7,10 (7), P3=6 -> pscore 6. CHK3 goes to DONE with no D3, dealer_win=1.
- Banker rule on pcard3: P=2,3 (5), D=1,5 (6), P3=7 -> banker draws. D3=13 -> pscore 2, dscore 6, dealer_win=1. Repeat with P3=8 -> the banker stands.
- Tie, banker-only draw: P=3,3 (6), D=2,2 (4) -> CHK goes to D3. D3=2 -> dscore 6, player_win = dealer_win = 1.
- Boundaries:
  - ctr goes 13 -> 1 across the wrap, and a deal on that edge loads 13;
  - deal during CHK is ignored and the card registers are unchanged;
  - deal in DONE clears all cards to 0 and returns to P1 with done=0.
